// File: rtl/dtcm_arbiter.sv
// Two-requester DTCM arbiter (LSU vs. external bus) with in-order response routing.
// Optional build macro DTCM_ARB_LSU_PRIO_EN selects fixed LSU priority instead of round-robin.
module dtcm_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned OUTS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            lsu_cmd_valid_i,
    output logic            lsu_cmd_ready_o,
    input  logic            lsu_cmd_read_i,
    input  logic [AW-1:0]   lsu_cmd_addr_i,
    input  logic [DW-1:0]   lsu_cmd_wdata_i,
    input  logic [DW/8-1:0] lsu_cmd_wmask_i,
    output logic            lsu_rsp_valid_o,
    input  logic            lsu_rsp_ready_i,
    output logic [DW-1:0]   lsu_rsp_rdata_o,

    input  logic            ext_cmd_valid_i,
    output logic            ext_cmd_ready_o,
    input  logic            ext_cmd_read_i,
    input  logic [AW-1:0]   ext_cmd_addr_i,
    input  logic [DW-1:0]   ext_cmd_wdata_i,
    input  logic [DW/8-1:0] ext_cmd_wmask_i,
    output logic            ext_rsp_valid_o,
    input  logic            ext_rsp_ready_i,
    output logic [DW-1:0]   ext_rsp_rdata_o,

    output logic            dtcm_cmd_valid_o,
    input  logic            dtcm_cmd_ready_i,
    output logic            dtcm_cmd_read_o,
    output logic [AW-1:0]   dtcm_cmd_addr_o,
    output logic [DW-1:0]   dtcm_cmd_wdata_o,
    output logic [DW/8-1:0] dtcm_cmd_wmask_o,
    input  logic            dtcm_rsp_valid_i,
    output logic            dtcm_rsp_ready_o,
    input  logic [DW-1:0]   dtcm_rsp_rdata_i
);

    localparam int unsigned PtrW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OUTS_DEPTH + 1);

    // Source encoding: 0 = LSU, 1 = EXT
    logic            last_grant_q, last_grant_d;
    logic            lock_q, lock_d;
    logic            lock_src_q, lock_src_d;
    logic            src_q [OUTS_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic grant;
    logic gnt_valid;
    logic fifo_full;
    logic fifo_empty;
    logic head_src;
    logic cmd_hs;
    logic rsp_hs;

    assign fifo_full  = (count_q == CntW'(OUTS_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_src   = src_q[rd_ptr_q];

    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_src_q;
`ifdef DTCM_ARB_LSU_PRIO_EN
        end else if (lsu_cmd_valid_i) begin
            grant = 1'b0;
        end else if (ext_cmd_valid_i) begin
            grant = 1'b1;
        end
`else
        end else if (lsu_cmd_valid_i && ext_cmd_valid_i) begin
            grant = ~last_grant_q;
        end else if (ext_cmd_valid_i) begin
            grant = 1'b1;
        end
`endif
    end

    assign gnt_valid = grant ? ext_cmd_valid_i : lsu_cmd_valid_i;

    // Full blocks the grant even if a pop happens this cycle: no rsp->cmd comb path.
    assign dtcm_cmd_valid_o = gnt_valid & ~fifo_full;
    assign dtcm_cmd_read_o  = grant ? ext_cmd_read_i  : lsu_cmd_read_i;
    assign dtcm_cmd_addr_o  = grant ? ext_cmd_addr_i  : lsu_cmd_addr_i;
    assign dtcm_cmd_wdata_o = grant ? ext_cmd_wdata_i : lsu_cmd_wdata_i;
    assign dtcm_cmd_wmask_o = grant ? ext_cmd_wmask_i : lsu_cmd_wmask_i;

    assign lsu_cmd_ready_o = ~grant & gnt_valid & dtcm_cmd_ready_i & ~fifo_full;
    assign ext_cmd_ready_o =  grant & gnt_valid & dtcm_cmd_ready_i & ~fifo_full;

    assign cmd_hs = dtcm_cmd_valid_o & dtcm_cmd_ready_i;

    assign lsu_rsp_valid_o  = ~fifo_empty & ~head_src & dtcm_rsp_valid_i;
    assign ext_rsp_valid_o  = ~fifo_empty &  head_src & dtcm_rsp_valid_i;
    assign lsu_rsp_rdata_o  = dtcm_rsp_rdata_i;
    assign ext_rsp_rdata_o  = dtcm_rsp_rdata_i;
    assign dtcm_rsp_ready_o = ~fifo_empty & (head_src ? ext_rsp_ready_i : lsu_rsp_ready_i);

    assign rsp_hs = dtcm_rsp_valid_i & dtcm_rsp_ready_o;

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (cmd_hs) begin
            last_grant_d = grant;
            lock_d       = 1'b0;
            wr_ptr_d     = (wr_ptr_q == PtrW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end else if (dtcm_cmd_valid_o) begin
            // Hold the presented command until the DTCM takes it.
            lock_d     = 1'b1;
            lock_src_d = grant;
        end

        if (rsp_hs) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end

        unique case ({cmd_hs, rsp_hs})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_src_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(OUTS_DEPTH); i++) begin
                src_q[i] <= 1'b0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (cmd_hs) begin
                src_q[wr_ptr_q] <= grant;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed, scoreboard-based bench for dtcm_arbiter (AW=16, DW=32, OUTS_DEPTH=2).
module tb_dtcm_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
    logic [AW-1:0] lsu_cmd_addr;
    logic [DW-1:0] lsu_cmd_wdata;
    logic [3:0]    lsu_cmd_wmask;
    logic          lsu_rsp_valid, lsu_rsp_ready;
    logic [DW-1:0] lsu_rsp_rdata;

    logic          ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
    logic [AW-1:0] ext_cmd_addr;
    logic [DW-1:0] ext_cmd_wdata;
    logic [3:0]    ext_cmd_wmask;
    logic          ext_rsp_valid, ext_rsp_ready;
    logic [DW-1:0] ext_rsp_rdata;

    logic          dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
    logic [AW-1:0] dtcm_cmd_addr;
    logic [DW-1:0] dtcm_cmd_wdata;
    logic [3:0]    dtcm_cmd_wmask;
    logic          dtcm_rsp_valid, dtcm_rsp_ready;
    logic [DW-1:0] dtcm_rsp_rdata;

    always #5 clk = ~clk;

    dtcm_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .OUTS_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lsu_cmd_valid_i  (lsu_cmd_valid),
        .lsu_cmd_ready_o  (lsu_cmd_ready),
        .lsu_cmd_read_i   (lsu_cmd_read),
        .lsu_cmd_addr_i   (lsu_cmd_addr),
        .lsu_cmd_wdata_i  (lsu_cmd_wdata),
        .lsu_cmd_wmask_i  (lsu_cmd_wmask),
        .lsu_rsp_valid_o  (lsu_rsp_valid),
        .lsu_rsp_ready_i  (lsu_rsp_ready),
        .lsu_rsp_rdata_o  (lsu_rsp_rdata),
        .ext_cmd_valid_i  (ext_cmd_valid),
        .ext_cmd_ready_o  (ext_cmd_ready),
        .ext_cmd_read_i   (ext_cmd_read),
        .ext_cmd_addr_i   (ext_cmd_addr),
        .ext_cmd_wdata_i  (ext_cmd_wdata),
        .ext_cmd_wmask_i  (ext_cmd_wmask),
        .ext_rsp_valid_o  (ext_rsp_valid),
        .ext_rsp_ready_i  (ext_rsp_ready),
        .ext_rsp_rdata_o  (ext_rsp_rdata),
        .dtcm_cmd_valid_o (dtcm_cmd_valid),
        .dtcm_cmd_ready_i (dtcm_cmd_ready),
        .dtcm_cmd_read_o  (dtcm_cmd_read),
        .dtcm_cmd_addr_o  (dtcm_cmd_addr),
        .dtcm_cmd_wdata_o (dtcm_cmd_wdata),
        .dtcm_cmd_wmask_o (dtcm_cmd_wmask),
        .dtcm_rsp_valid_i (dtcm_rsp_valid),
        .dtcm_rsp_ready_o (dtcm_rsp_ready),
        .dtcm_rsp_rdata_i (dtcm_rsp_rdata)
    );

    typedef struct packed {
        logic        src;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expect the granted command this cycle (dtcm_cmd_ready must be 1) and record its response.
    task automatic expect_cmd(input string tag, input logic src, input logic [AW-1:0] addr,
                              input logic [31:0] rdata);
        chk({tag, ".valid"}, 64'(dtcm_cmd_valid), 64'(1));
        chk({tag, ".addr"}, 64'(dtcm_cmd_addr), 64'(addr));
        chk({tag, ".lsu_rdy"}, 64'(lsu_cmd_ready), 64'(!src));
        chk({tag, ".ext_rdy"}, 64'(ext_cmd_ready), 64'(src));
        sb.push_back('{src: src, data: rdata});
    endtask

    task automatic drive_rsp();
        if (sb.size() > 0) begin
            dtcm_rsp_valid = 1'b1;
            dtcm_rsp_rdata = sb[0].data;
        end else begin
            dtcm_rsp_valid = 1'b0;
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        logic rdy;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed 0 entries expected >=1", tag);
            return;
        end
        e   = sb[0];
        rdy = e.src ? ext_rsp_ready : lsu_rsp_ready;
        chk({tag, ".lsu_v"}, 64'(lsu_rsp_valid), 64'(!e.src));
        chk({tag, ".ext_v"}, 64'(ext_rsp_valid), 64'(e.src));
        chk({tag, ".rdata"}, 64'(e.src ? ext_rsp_rdata : lsu_rsp_rdata), 64'(e.data));
        chk({tag, ".dtcm_rdy"}, 64'(dtcm_rsp_ready), 64'(rdy));
        if (rdy) void'(sb.pop_front());
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".cmd_v"}, 64'(dtcm_cmd_valid), 64'(0));
        chk({tag, ".lsu_cr"}, 64'(lsu_cmd_ready), 64'(0));
        chk({tag, ".ext_cr"}, 64'(ext_cmd_ready), 64'(0));
        chk({tag, ".lsu_rv"}, 64'(lsu_rsp_valid), 64'(0));
        chk({tag, ".ext_rv"}, 64'(ext_rsp_valid), 64'(0));
        chk({tag, ".rsp_rdy"}, 64'(dtcm_rsp_ready), 64'(0));
    endtask

    initial begin
        logic exp_src;
        rst_n          = 1'b0;
        lsu_cmd_valid  = 1'b0; lsu_cmd_read = 1'b0; lsu_cmd_addr = '0;
        lsu_cmd_wdata  = '0;   lsu_cmd_wmask = '0;  lsu_rsp_ready = 1'b1;
        ext_cmd_valid  = 1'b0; ext_cmd_read = 1'b0; ext_cmd_addr = '0;
        ext_cmd_wdata  = '0;   ext_cmd_wmask = '0;  ext_rsp_ready = 1'b1;
        dtcm_cmd_ready = 1'b0; dtcm_rsp_valid = 1'b0; dtcm_rsp_rdata = '0;

        // Reset and idle
        @(negedge clk); #1;
        check_quiet("reset");
        @(negedge clk); rst_n = 1'b1; dtcm_cmd_ready = 1'b1; #1;
        check_quiet("idle");

        // Simultaneous LSU read / EXT write: LSU first
        @(negedge clk);
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0010;
        ext_cmd_valid = 1'b1; ext_cmd_read = 1'b0; ext_cmd_addr = 16'h0020;
        ext_cmd_wmask = 4'hF; ext_cmd_wdata = 32'hCAFE_0020; #1;
        expect_cmd("tie_lsu", 1'b0, 16'h0010, 32'h1111_0010);
        chk("tie_lsu.read", 64'(dtcm_cmd_read), 64'(1));
        @(negedge clk); lsu_cmd_valid = 1'b0; #1;
        expect_cmd("tie_ext", 1'b1, 16'h0020, 32'h2222_0020);
        chk("tie_ext.read", 64'(dtcm_cmd_read), 64'(0));
        chk("tie_ext.wmask", 64'(dtcm_cmd_wmask), 64'(4'hF));
        chk("tie_ext.wdata", 64'(dtcm_cmd_wdata), 64'(32'hCAFE_0020));
        @(negedge clk); ext_cmd_valid = 1'b0; drive_rsp(); #1;
        chk("full_idle.cmd_v", 64'(dtcm_cmd_valid), 64'(0));
        check_rsp("rsp1");
        @(negedge clk); drive_rsp(); #1;
        check_rsp("rsp2");
        @(negedge clk); dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h5555_AAAA; #1;
        check_quiet("stray");

        // Lock: EXT stalled for 3 cycles, LSU appears meanwhile
        @(negedge clk);
        dtcm_rsp_valid = 1'b0; dtcm_cmd_ready = 1'b0;
        ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0030; #1;
        chk("lock0.valid", 64'(dtcm_cmd_valid), 64'(1));
        chk("lock0.addr", 64'(dtcm_cmd_addr), 64'(16'h0030));
        chk("lock0.ext_rdy", 64'(ext_cmd_ready), 64'(0));
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0040; #1;
            chk("lock.addr", 64'(dtcm_cmd_addr), 64'(16'h0030));
            chk("lock.lsu_rdy", 64'(lsu_cmd_ready), 64'(0));
        end
        @(negedge clk); dtcm_cmd_ready = 1'b1; #1;
        expect_cmd("lock_rel", 1'b1, 16'h0030, 32'h3333_0030);
        @(negedge clk); ext_cmd_valid = 1'b0; #1;
        expect_cmd("after_lock", 1'b0, 16'h0040, 32'hDEAD_BEEF);

        // FIFO full: pop in the same cycle must not admit the new command
        @(negedge clk);
        lsu_cmd_valid = 1'b0;
        ext_cmd_valid = 1'b1; ext_cmd_addr = 16'h0050;
        drive_rsp(); #1;
        chk("full.cmd_v", 64'(dtcm_cmd_valid), 64'(0));
        chk("full.ext_rdy", 64'(ext_cmd_ready), 64'(0));
        check_rsp("full_pop");
        @(negedge clk); dtcm_rsp_valid = 1'b0; #1;
        expect_cmd("after_pop", 1'b1, 16'h0050, 32'h5555_0050);

        // LSU response backpressure
        @(negedge clk); ext_cmd_valid = 1'b0; lsu_rsp_ready = 1'b0; drive_rsp(); #1;
        for (int i = 0; i < 3; i++) begin
            check_rsp("bp_hold");
            @(negedge clk); #1;
        end
        lsu_rsp_ready = 1'b1; #1;
        check_rsp("bp_release");
        @(negedge clk); drive_rsp(); #1;
        check_rsp("bp_ext");
        @(negedge clk); dtcm_rsp_valid = 1'b0;

        // Continuous requests from both sides: 8 accepts
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_rsp();
            lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'(16'h0100 + i);
            ext_cmd_valid = 1'b1; ext_cmd_addr = 16'(16'h0200 + i);
            #1;
`ifdef DTCM_ARB_LSU_PRIO_EN
            exp_src = 1'b0;
`else
            exp_src = (i % 2) == 1;
`endif
            if (dtcm_rsp_valid) check_rsp("rr_rsp");
            expect_cmd("rr_cmd", exp_src, exp_src ? 16'(16'h0200 + i) : 16'(16'h0100 + i),
                       32'(32'h7000_0000 + i));
        end
        @(negedge clk); lsu_cmd_valid = 1'b0; ext_cmd_valid = 1'b0; drive_rsp(); #1;
        check_rsp("rr_drain");

        // Reset with two outstanding commands
        @(negedge clk); dtcm_rsp_valid = 1'b0;
        lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'h0060; #1;
        expect_cmd("pre_rst0", 1'b0, 16'h0060, 32'h0);
        @(negedge clk); lsu_cmd_addr = 16'h0061; #1;
        expect_cmd("pre_rst1", 1'b0, 16'h0061, 32'h0);
        @(negedge clk); lsu_cmd_valid = 1'b0; rst_n = 1'b0; #1;
        check_quiet("in_rst");
        @(negedge clk); rst_n = 1'b1; sb.delete();
        @(negedge clk); dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h1234_5678; #1;
        check_quiet("post_rst_stray");
        @(negedge clk); dtcm_rsp_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
